// File: rtl/vect_pkg.sv
// Shared vector types, FSM states and a signed clamp helper.
// Used by the FIR accumulator, alu_vect_2 and their benches.
package vect_pkg;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;

  typedef logic signed [LANE_W-1:0] lane_t;
  typedef lane_t [0:LANES-1]        vec_t;

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  // Clamp v into the signed range of a w-bit number.
  function automatic logic signed [63:0] sat_to(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/vect_lane_sum.sv
// Combinational full-width signed reduction of M lanes.
// Ports: i_data (M lanes of N bits), o_sum (N+clog2(M) bits).
module vect_lane_sum #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic [0:M-1][N-1:0]           i_data,
  output logic signed [N+$clog2(M)-1:0] o_sum
);

  localparam int SW = N + $clog2(M);

  always_comb begin
    o_sum = '0;
    for (int i = 0; i < M; i++) begin
      o_sum = o_sum + SW'($signed(i_data[i]));
    end
  end

endmodule

// File: rtl/vect_fir_accum.sv
// FIR tap accumulator: reduces lane products per beat, sums beats
// per sample, rounds/shifts/saturates and hands out via valid/ready.
// Ports: clk, rst_n, in_valid/in_ready/in_data/in_last (beats),
// out_valid/out_ready/out_data/out_sat/out_beats (samples).
module vect_fir_accum
  import vect_pkg::*;
#(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int ACC_W = 24,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:M-1][N-1:0]     in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat,
  output logic [CNT_W-1:0]        out_beats
);

  localparam int SW = N + $clog2(M);
  localparam logic signed [ACC_W:0] RND =
    (ACC_W+1)'((1 << SHIFT) >> 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic                    r_ovf;
  logic                    w_ovf_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic signed [SW-1:0]    w_lane_sum;
  logic signed [ACC_W:0]   w_sum_wide;
  logic signed [ACC_W:0]   w_rnd;
  logic signed [ACC_W:0]   w_shr;
  logic signed [63:0]      w_shr64;
  logic signed [63:0]      w_sat64;
  logic                    w_acc_sat;
  logic                    w_clamp;
  logic                    w_acc_wr;
  logic                    w_load;

  vect_lane_sum #(
    .N (N),
    .M (M)
  ) u_sum (
    .i_data (in_data),
    .o_sum  (w_lane_sum)
  );

  // acc is always zero in HOLD, so a beat taken there
  // naturally starts a fresh sample.
  assign w_sum_wide = (ACC_W+1)'(r_acc)
                    + (ACC_W+1)'(w_lane_sum);
  assign w_acc_sat  = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];

  always_comb begin
    w_acc_nxt = w_sum_wide[ACC_W-1:0];
    if (w_acc_sat) begin
      w_acc_nxt = w_sum_wide[ACC_W]
                ? {1'b1, {(ACC_W-1){1'b0}}}
                : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  assign w_ovf_nxt = r_ovf | w_acc_sat;
  assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  // One extra bit keeps the rounding add from wrapping.
  assign w_rnd   = (ACC_W+1)'(w_acc_nxt) + RND;
  assign w_shr   = w_rnd >>> SHIFT;
  assign w_shr64 = 64'(w_shr);
  assign w_sat64 = sat_to(w_shr64, OUT_W);
  assign w_clamp = (w_sat64 != w_shr64);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b1;
    out_valid   = 1'b0;
    w_acc_wr    = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      ACCUM: begin
        if (in_valid) begin
          if (in_last) begin
            w_load      = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_acc_wr = 1'b1;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid && in_last) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ACCUM;
            w_acc_wr    = in_valid;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ACCUM;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_cnt     <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_beats <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_acc     <= '0;
        r_ovf     <= 1'b0;
        r_cnt     <= '0;
        out_data  <= OUT_W'(w_sat64);
        out_sat   <= w_ovf_nxt | w_clamp;
        out_beats <= w_cnt_nxt;
      end else if (w_acc_wr) begin
        r_acc <= w_acc_nxt;
        r_ovf <= w_ovf_nxt;
        r_cnt <= w_cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vect_fir_accum.sv
// Scoreboard bench for vect_fir_accum: two instances (SHIFT 0 and 2)
// share stimulus; a reference model queues expected samples.
module tb_vect_fir_accum;
  import vect_pkg::*;

  localparam int N     = 8;
  localparam int M     = 4;
  localparam int ACC_W = 24;
  localparam int OUT_W = 16;
  localparam int CNT_W = 8;
  localparam int SH0   = 0;
  localparam int SH1   = 2;

  typedef struct {
    longint data;
    bit     sat;
    longint beats;
  } exp_t;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic in_valid  = 1'b0;
  logic in_last   = 1'b0;
  logic out_ready = 1'b1;
  logic [0:M-1][N-1:0] in_data = '0;

  logic rdy0, rdy1, v0, v1, s0, s1;
  logic signed [OUT_W-1:0] d0, d1;
  logic [CNT_W-1:0] b0, b1;

  int     checks = 0;
  int     errors = 0;
  exp_t   q0[$];
  exp_t   q1[$];
  longint m_tot = 0;
  bit     m_ovf = 0;
  longint m_cnt = 0;
  bit     rdy_rand = 0;

  always #5 clk = ~clk;

  vect_fir_accum #(
    .N(N), .M(M), .ACC_W(ACC_W), .OUT_W(OUT_W),
    .SHIFT(SH0), .CNT_W(CNT_W)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_last(in_last),
    .out_valid(v0), .out_ready(out_ready),
    .out_data(d0), .out_sat(s0), .out_beats(b0)
  );

  vect_fir_accum #(
    .N(N), .M(M), .ACC_W(ACC_W), .OUT_W(OUT_W),
    .SHIFT(SH1), .CNT_W(CNT_W)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_last(in_last),
    .out_valid(v1), .out_ready(out_ready),
    .out_data(d1), .out_sat(s1), .out_beats(b1)
  );

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic vec_t vec(input int a, b, c, d);
    vec_t v;
    v[0] = N'(a);
    v[1] = N'(b);
    v[2] = N'(c);
    v[3] = N'(d);
    return v;
  endfunction

  // Reference: plain integer arithmetic on the spec rules.
  function automatic exp_t mk(input longint t, input int sh);
    exp_t   e;
    longint r;
    longint hi;
    hi = (64'sd1 <<< (OUT_W - 1)) - 1;
    r  = (t + ((64'sd1 <<< sh) >>> 1)) >>> sh;
    e.sat = m_ovf;
    if (r > hi) begin
      r = hi;
      e.sat = 1'b1;
    end else if (r < -hi - 1) begin
      r = -hi - 1;
      e.sat = 1'b1;
    end
    e.data  = r;
    e.beats = m_cnt;
    return e;
  endfunction

  task automatic model_beat(input vec_t v, input bit last);
    longint hi;
    longint s;
    hi = (64'sd1 <<< (ACC_W - 1)) - 1;
    s  = 0;
    for (int i = 0; i < M; i++) s += longint'(v[i]);
    m_tot += s;
    if (m_tot > hi) begin
      m_tot = hi;
      m_ovf = 1'b1;
    end else if (m_tot < -hi - 1) begin
      m_tot = -hi - 1;
      m_ovf = 1'b1;
    end
    if (m_cnt < (2**CNT_W) - 1) m_cnt++;
    if (last) begin
      q0.push_back(mk(m_tot, SH0));
      q1.push_back(mk(m_tot, SH1));
      m_tot = 0;
      m_ovf = 1'b0;
      m_cnt = 0;
    end
  endtask

  task automatic model_reset();
    m_tot = 0;
    m_ovf = 1'b0;
    m_cnt = 0;
    q0.delete();
    q1.delete();
  endtask

  task automatic beat(input vec_t v, input bit last);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    in_last  = last;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      ok = rdy0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat accept timeout");
    end else begin
      model_beat(v, last);
    end
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    in_last  = 1'b1;
    in_data  = $urandom;
    repeat (n) @(posedge clk);
    #1;
    in_last = 1'b0;
  endtask

  task automatic drain();
    int t;
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain timeout left %0d %0d",
               q0.size(), q1.size());
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n && v0 && out_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0 unexpected sample %0d", d0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("dut0 data", d0, e.data);
        chk("dut0 sat", s0, e.sat);
        chk("dut0 beats", b0, e.beats);
      end
    end
    if (rst_n && v1 && out_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 unexpected sample %0d", d1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1 data", d1, e.data);
        chk("dut1 sat", s1, e.sat);
        chk("dut1 beats", b1, e.beats);
      end
    end
  end

  initial begin
    logic signed [OUT_W-1:0] hold_d;
    int len;

    #2;
    chk("rst valid", v0, 0);
    chk("rst data", d0, 0);
    chk("rst sat", s0, 0);
    chk("rst beats", b0, 0);
    chk("rst in_ready", rdy0, 1);
    chk("rst valid1", v1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    beat(vec(1, 2, 3, 4), 1'b1);
    @(negedge clk);
    chk("single latency", v0, 1);
    drain();

    beat(vec(-1, -1, -1, -1), 1'b0);
    beat(vec(10, 0, 0, 0), 1'b0);
    beat(vec(0, 0, 0, 5), 1'b1);
    @(negedge clk);
    chk("multi latency", v0, 1);
    drain();

    beat(vec(127, 127, 127, 127), 1'b1);
    beat(vec(-3, 0, 0, 0), 1'b1);
    drain();

    for (int i = 0; i < 100; i++)
      beat(vec(127, 127, 127, 127), i == 99);
    for (int i = 0; i < 70; i++)
      beat(vec(-128, -128, -128, -128), i == 69);
    drain();

    // Long enough to saturate the accumulator and the counter.
    for (int i = 0; i < 16600; i++)
      beat(vec(127, 127, 127, 127), i == 16599);
    drain();

    out_ready = 1'b0;
    beat(vec(1, 2, 3, 4), 1'b1);
    @(negedge clk);
    hold_d = d0;
    chk("bp first data", d0, 10);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = vec(2, 2, 2, 2);
    in_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp in_ready", rdy0, 0);
      chk("bp valid", v0, 1);
      chk("bp stable", d0, hold_d);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    beat(vec(2, 2, 2, 2), 1'b1);
    @(negedge clk);
    chk("bp no bubble", v0, 1);
    chk("bp new data", d0, 8);
    drain();

    beat(vec(5, 5, 5, 5), 1'b0);
    beat(vec(5, 5, 5, 5), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst valid", v0, 0);
    chk("midrst data", d0, 0);
    chk("midrst sat", s0, 0);
    chk("midrst beats", b0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(vec(1, 1, 1, 1), 1'b1);
    drain();

    rdy_rand = 1'b1;
    for (int s = 0; s < 60; s++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
        beat(vec_t'($urandom), b == len - 1);
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
